// File: rtl/aabb_slab_intersector_if.sv
// Shared fixed-point ray/box types and the request/result interface of the slab intersector.
// The master drives one ray+box per cycle with no backpressure; the slave returns results in order.
package aabb_pkg;
  localparam int WIDTH  = 24;
  localparam int Q_BITS = 12;

  typedef logic signed [WIDTH-1:0] scalar_t;

  localparam scalar_t MAX     = {1'b0, {(WIDTH-1){1'b1}}};
  localparam scalar_t MIN     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam scalar_t ONE     = scalar_t'(1) <<< Q_BITS;
  localparam scalar_t NEG_ONE = -ONE;

  typedef struct packed {
    scalar_t x;
    scalar_t y;
    scalar_t z;
  } Vec3;

  typedef struct packed {
    Vec3 origin;
    Vec3 direction;
  } Ray;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } Color;

  typedef struct packed {
    Vec3  min;
    Vec3  max;
    Color color;
  } AABB;

  typedef struct packed {
    AABB     box;
    logic    ray_hit;
    scalar_t tmin;
    Vec3     normal;
  } AABB_result_t;
endpackage

interface aabb_slab_intersector_if;
  import aabb_pkg::*;

  logic         start;
  Ray           ray_in;
  AABB          aabb_box;
  AABB_result_t test_result;
  logic         valid_out;

  modport master (
    output start,
    output ray_in,
    output aabb_box,
    input  test_result,
    input  valid_out
  );

  modport slave (
    input  start,
    input  ray_in,
    input  aabb_box,
    output test_result,
    output valid_out
  );
endinterface

// File: rtl/aabb_slab_intersector.sv
// Ray vs. axis-aligned box test using the slab method in signed Q12 fixed point.
// Four register stages, latency 4, one ray per cycle, never stalls.
module aabb_slab_intersector
  import aabb_pkg::*;
(
  input logic                    clk,
  input logic                    reset,
  aabb_slab_intersector_if.slave bus
);

  localparam int DW = WIDTH + 1;
  // One extra quotient bit so that (-2^24 << Q) / -1 cannot wrap before saturation.
  localparam int NW = DW + Q_BITS + 1;

  typedef logic signed [DW-1:0] diff_t;
  typedef logic signed [NW-1:0] quo_t;

  localparam quo_t Q_MAX = quo_t'(MAX);
  localparam quo_t Q_MIN = quo_t'(MIN);

  localparam AABB BOX_RST = '{'{MIN, MIN, MIN}, '{MAX, MAX, MAX}, '0};
  localparam AABB_result_t RES_RST = '{BOX_RST, 1'b0, MAX, '0};

  function automatic scalar_t axis(input Vec3 v, input int a);
    case (a)
      0:       axis = v.x;
      1:       axis = v.y;
      default: axis = v.z;
    endcase
  endfunction

  function automatic diff_t widen(input scalar_t s);
    widen = diff_t'(s);
  endfunction

  function automatic scalar_t slab_div(input diff_t num_d, input scalar_t den_s);
    quo_t num;
    quo_t den;
    quo_t q;
    num = quo_t'(num_d) <<< Q_BITS;
    den = quo_t'(den_s);
    q   = num / den;
    if (q > Q_MAX)
      slab_div = MAX;
    else if (q < Q_MIN)
      slab_div = MIN;
    else
      slab_div = scalar_t'(q);
  endfunction

  // ---------------- S1: slab offsets relative to the origin
  diff_t w_dmin [3];
  diff_t w_dmax [3];

  logic  r_s1_vld;
  Ray    r_s1_ray;
  AABB   r_s1_box;
  diff_t r_s1_dmin [3];
  diff_t r_s1_dmax [3];

  always_comb begin
    for (int a = 0; a < 3; a++) begin
      w_dmin[a] = widen(axis(bus.aabb_box.min, a)) - widen(axis(bus.ray_in.origin, a));
      w_dmax[a] = widen(axis(bus.aabb_box.max, a)) - widen(axis(bus.ray_in.origin, a));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_vld <= 1'b0;
      r_s1_ray <= '0;
      r_s1_box <= BOX_RST;
      for (int a = 0; a < 3; a++) begin
        r_s1_dmin[a] <= '0;
        r_s1_dmax[a] <= '0;
      end
    end else begin
      r_s1_vld <= bus.start;
      if (bus.start) begin
        r_s1_ray <= bus.ray_in;
        r_s1_box <= bus.aabb_box;
        for (int a = 0; a < 3; a++) begin
          r_s1_dmin[a] <= w_dmin[a];
          r_s1_dmax[a] <= w_dmax[a];
        end
      end
    end
  end

  // ---------------- S2: slab distances; a zero direction is unbounded or a guaranteed miss
  scalar_t    w_lo [3];
  scalar_t    w_hi [3];
  logic [2:0] w_miss;
  logic [2:0] w_dneg;

  logic       r_s2_vld;
  AABB        r_s2_box;
  scalar_t    r_s2_lo [3];
  scalar_t    r_s2_hi [3];
  logic [2:0] r_s2_miss;
  logic [2:0] r_s2_dneg;

  always_comb begin
    w_miss = '0;
    w_dneg = '0;
    for (int a = 0; a < 3; a++) begin
      w_lo[a]   = MIN;
      w_hi[a]   = MAX;
      w_dneg[a] = axis(r_s1_ray.direction, a) < 0;
      if (axis(r_s1_ray.direction, a) == '0) begin
        w_miss[a] = (axis(r_s1_ray.origin, a) < axis(r_s1_box.min, a)) ||
                    (axis(r_s1_ray.origin, a) > axis(r_s1_box.max, a));
      end else begin
        w_lo[a] = slab_div(r_s1_dmin[a], axis(r_s1_ray.direction, a));
        w_hi[a] = slab_div(r_s1_dmax[a], axis(r_s1_ray.direction, a));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_vld  <= 1'b0;
      r_s2_box  <= BOX_RST;
      r_s2_miss <= '0;
      r_s2_dneg <= '0;
      for (int a = 0; a < 3; a++) begin
        r_s2_lo[a] <= '0;
        r_s2_hi[a] <= '0;
      end
    end else begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_box  <= r_s1_box;
        r_s2_miss <= w_miss;
        r_s2_dneg <= w_dneg;
        for (int a = 0; a < 3; a++) begin
          r_s2_lo[a] <= w_lo[a];
          r_s2_hi[a] <= w_hi[a];
        end
      end
    end
  end

  // ---------------- S3: interval intersection across axes, entry axis with x > y > z on ties
  scalar_t    w_near [3];
  scalar_t    w_far  [3];
  scalar_t    w_tn;
  scalar_t    w_tf;
  logic [1:0] w_entry;
  logic       w_entry_dneg;

  logic       r_s3_vld;
  AABB        r_s3_box;
  scalar_t    r_s3_tn;
  scalar_t    r_s3_tf;
  logic       r_s3_miss;
  logic [1:0] r_s3_entry;
  logic       r_s3_dneg;

  always_comb begin
    for (int a = 0; a < 3; a++) begin
      if (r_s2_lo[a] <= r_s2_hi[a]) begin
        w_near[a] = r_s2_lo[a];
        w_far[a]  = r_s2_hi[a];
      end else begin
        w_near[a] = r_s2_hi[a];
        w_far[a]  = r_s2_lo[a];
      end
    end

    w_tn    = w_near[0];
    w_entry = 2'd0;
    if (w_near[1] > w_tn) begin
      w_tn    = w_near[1];
      w_entry = 2'd1;
    end
    if (w_near[2] > w_tn) begin
      w_tn    = w_near[2];
      w_entry = 2'd2;
    end

    w_tf = w_far[0];
    if (w_far[1] < w_tf) w_tf = w_far[1];
    if (w_far[2] < w_tf) w_tf = w_far[2];

    case (w_entry)
      2'd0:    w_entry_dneg = r_s2_dneg[0];
      2'd1:    w_entry_dneg = r_s2_dneg[1];
      default: w_entry_dneg = r_s2_dneg[2];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s3_vld   <= 1'b0;
      r_s3_box   <= BOX_RST;
      r_s3_tn    <= '0;
      r_s3_tf    <= '0;
      r_s3_miss  <= 1'b0;
      r_s3_entry <= '0;
      r_s3_dneg  <= 1'b0;
    end else begin
      r_s3_vld <= r_s2_vld;
      if (r_s2_vld) begin
        r_s3_box   <= r_s2_box;
        r_s3_tn    <= w_tn;
        r_s3_tf    <= w_tf;
        r_s3_miss  <= |r_s2_miss;
        r_s3_entry <= w_entry;
        r_s3_dneg  <= w_entry_dneg;
      end
    end
  end

  // ---------------- S4: hit decision, clamped entry distance and outward normal
  AABB_result_t w_res;
  scalar_t      w_nrm;

  logic         r_vld;
  AABB_result_t r_res;

  always_comb begin
    w_res.box     = r_s3_box;
    w_res.ray_hit = 1'b0;
    w_res.tmin    = MAX;
    w_res.normal  = '0;
    w_nrm         = r_s3_dneg ? ONE : NEG_ONE;
    if (!r_s3_miss && (r_s3_tn <= r_s3_tf) && !r_s3_tf[WIDTH-1]) begin
      w_res.ray_hit = 1'b1;
      if (r_s3_tn[WIDTH-1]) begin
        w_res.tmin = '0;
      end else begin
        w_res.tmin = r_s3_tn;
        case (r_s3_entry)
          2'd0:    w_res.normal.x = w_nrm;
          2'd1:    w_res.normal.y = w_nrm;
          default: w_res.normal.z = w_nrm;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld <= 1'b0;
      r_res <= RES_RST;
    end else begin
      r_vld <= r_s3_vld;
      if (r_s3_vld) r_res <= w_res;
    end
  end

  assign bus.valid_out   = r_vld;
  assign bus.test_result = r_res;

endmodule

// File: tb/tb_aabb_slab_intersector.sv
// Directed-vector bench for aabb_slab_intersector: latency, results, streaming order, reset flush.
module tb_aabb_slab_intersector;
  import aabb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  aabb_slab_intersector_if bus ();

  aabb_slab_intersector dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    Ray      ray;
    AABB     box;
    logic    hit;
    scalar_t tmin;
    Vec3     normal;
  } vec_t;

  localparam int NV = 13;
  vec_t tv [NV];
  AABB  box_a;
  int   total = 0;
  int   bad   = 0;

  function automatic Vec3 v3(input logic [23:0] x, input logic [23:0] y, input logic [23:0] z);
    Vec3 v;
    v.x = x;
    v.y = y;
    v.z = z;
    return v;
  endfunction

  function automatic vec_t mk(input Vec3 o, input Vec3 d, input logic h,
                              input logic [23:0] t, input Vec3 n);
    vec_t r;
    r.ray.origin    = o;
    r.ray.direction = d;
    r.box           = box_a;
    r.hit           = h;
    r.tmin          = t;
    r.normal        = n;
    return r;
  endfunction

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.ray_in   = v.ray;
    bus.aabb_box = v.box;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.ray_in = '0;
    repeat (2) @(negedge clk);
    check($sformatf("v%0d early_vld", idx), bus.valid_out, 1'b0);
    @(negedge clk);
    check($sformatf("v%0d vld", idx), bus.valid_out, 1'b1);
    check($sformatf("v%0d hit", idx), bus.test_result.ray_hit, v.hit);
    check($sformatf("v%0d tmin", idx), bus.test_result.tmin, v.tmin);
    check($sformatf("v%0d normal", idx), bus.test_result.normal, v.normal);
    check($sformatf("v%0d box", idx), bus.test_result.box, v.box);
    @(negedge clk);
    check($sformatf("v%0d pulse_end", idx), bus.valid_out, 1'b0);
  endtask

  // Start at cycle i uses tv[i%2]; its result must appear exactly 4 negedges later.
  task automatic stream(input logic [15:0] pat, input int n, input string name);
    logic exp_v;
    for (int j = 0; j < n + 5; j++) begin
      @(negedge clk);
      exp_v = 1'b0;
      if (j >= 4 && j - 4 < n) exp_v = pat[j-4];
      check($sformatf("%s vld c%0d", name, j), bus.valid_out, exp_v);
      if (exp_v) begin
        check($sformatf("%s hit c%0d", name, j), bus.test_result.ray_hit, tv[(j-4)%2].hit);
        check($sformatf("%s tmin c%0d", name, j), bus.test_result.tmin, tv[(j-4)%2].tmin);
      end
      bus.start = 1'b0;
      if (j < n && pat[j]) begin
        bus.start    = 1'b1;
        bus.ray_in   = tv[j%2].ray;
        bus.aabb_box = tv[j%2].box;
      end
    end
    bus.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start    = 1'b0;
    bus.ray_in   = '0;
    bus.aabb_box = '0;

    box_a.min   = v3(24'h000000, 24'h000000, 24'hFFF000);
    box_a.max   = v3(24'h000C00, 24'h000C00, 24'h001000);
    box_a.color = '{8'hFF, 8'h00, 8'h00};

    tv[0]  = mk(v3(24'h000000, 24'h000000, 24'hFFE000), v3(24'h0, 24'h0, 24'h001000), 1'b1, 24'h001000, v3(24'h0, 24'h0, 24'hFFF000));
    tv[1]  = mk(v3(24'hFFF800, 24'h000000, 24'hFFE000), v3(24'h0, 24'h0, 24'h001000), 1'b0, 24'h7FFFFF, v3(24'h0, 24'h0, 24'h0));
    tv[2]  = mk(v3(24'hFFF000, 24'h000400, 24'h000000), v3(24'h001000, 24'h0, 24'h0), 1'b1, 24'h001000, v3(24'hFFF000, 24'h0, 24'h0));
    tv[3]  = mk(v3(24'h000400, 24'h000400, 24'h000000), v3(24'h0, 24'h0, 24'h001000), 1'b1, 24'h000000, v3(24'h0, 24'h0, 24'h0));
    tv[4]  = mk(v3(24'h000400, 24'h000400, 24'h002000), v3(24'h0, 24'h0, 24'h001000), 1'b0, 24'h7FFFFF, v3(24'h0, 24'h0, 24'h0));
    tv[5]  = mk(v3(24'h000400, 24'h000400, 24'h003000), v3(24'h0, 24'h0, 24'hFFF000), 1'b1, 24'h002000, v3(24'h0, 24'h0, 24'h001000));
    tv[6]  = mk(v3(24'h000C00, 24'h000000, 24'hFFE000), v3(24'h0, 24'h0, 24'h001000), 1'b1, 24'h001000, v3(24'h0, 24'h0, 24'hFFF000));
    tv[7]  = mk(v3(24'h000C01, 24'h000000, 24'hFFE000), v3(24'h0, 24'h0, 24'h001000), 1'b0, 24'h7FFFFF, v3(24'h0, 24'h0, 24'h0));
    tv[8]  = mk(v3(24'hFFF000, 24'hFFF000, 24'h000000), v3(24'h001000, 24'h001000, 24'h0), 1'b1, 24'h001000, v3(24'hFFF000, 24'h0, 24'h0));
    tv[9]  = mk(v3(24'h000400, 24'h000400, 24'hFFE000), v3(24'h0, 24'h0, 24'h003000), 1'b1, 24'h000555, v3(24'h0, 24'h0, 24'hFFF000));
    tv[10] = mk(v3(24'h000400, 24'h000400, 24'hFFE000), v3(24'h0, 24'h0, 24'h000001), 1'b1, 24'h7FFFFF, v3(24'h0, 24'h0, 24'hFFF000));
    tv[11] = mk(v3(24'h000400, 24'h002000, 24'h000000), v3(24'h0, 24'hFFF000, 24'h0), 1'b1, 24'h001400, v3(24'h0, 24'h001000, 24'h0));
    tv[12] = mk(v3(24'h000400, 24'h000400, 24'h000000), v3(24'h0, 24'h0, 24'h0), 1'b1, 24'h000000, v3(24'h0, 24'h0, 24'h0));
    for (int i = 0; i < NV; i++) tv[i].box.color.g = 8'(i);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst vld", bus.valid_out, 1'b0);
    check("rst hit", bus.test_result.ray_hit, 1'b0);
    check("rst tmin", bus.test_result.tmin, 24'h7FFFFF);
    check("rst normal", bus.test_result.normal, 72'h0);
    check("rst box", bus.test_result.box,
          {24'h800000, 24'h800000, 24'h800000, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h000000});
    reset = 1'b0;

    for (int i = 0; i < NV; i++) apply(tv[i], i);

    stream(16'h00FF, 8, "stream");
    stream(16'b0000_0000_0010_1101, 6, "gaps");

    // Reset two cycles into flight must flush the ray
    @(negedge clk);
    bus.start    = 1'b1;
    bus.ray_in   = tv[0].ray;
    bus.aabb_box = tv[0].box;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst vld", bus.valid_out, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("flush vld c%0d", k), bus.valid_out, 1'b0);
      check($sformatf("flush tmin c%0d", k), bus.test_result.tmin, 24'h7FFFFF);
      check($sformatf("flush hit c%0d", k), bus.test_result.ray_hit, 1'b0);
    end
    apply(tv[2], 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aabb_slab_intersector.md
Name: aabb_slab_intersector

Overview:
- Fixed-point ray / axis-aligned-box intersection core using the slab method.
- In the scene intersector, one instance sits per scene box behind the ray generator.
- All instances receive the same ray stream; their results go to a nearest-hit selector and then to the Lambertian shader.
- Fully pipelined: accepts one ray per cycle and returns hit flag, entry distance, surface normal and the box (with its colour).

Parameters:
- WIDTH, 24, bit width of every signed fixed-point scalar.
- Q_BITS, 12, fractional bits; 1.0 = 0x001000.
- MAX, 24'h7FFFFF, most positive scalar; used as +infinity and as the no-hit distance.
- MIN, 24'h800000, most negative scalar; used as -infinity.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  ray_in/aabb_box valid this cycle.
- ray_in  input  Ray  origin{x,y,z}, direction{x,y,z}, each component WIDTH signed.
- aabb_box  input  AABB  min{x,y,z}, max{x,y,z} (WIDTH signed), color{r,g,b} (8 bit each).
- test_result  output  AABB_result_t  fields: box, ray_hit, tmin (WIDTH), normal{x,y,z} (WIDTH).
- valid_out  output  1  test_result valid.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high.
- On reset:
  - valid_out=0; all pipeline valids=0.
  - test_result: ray_hit=0, tmin=MAX, normal=0; box fields min=MIN, max=MAX, color=0.
- Pipeline: 4 stages, latency exactly 4 cycles from start to valid_out, throughput 1 per cycle, no stall.
- Each stage carries a valid bit. Ray and box are captured with start and travel with their data.
- S1, per axis a:
  - dmin = box.min.a - origin.a; dmax = box.max.a - origin.a.
  - Computed at WIDTH+1 bits.
- S2, per axis with direction component d != 0:
  - t_lo = (dmin << Q_BITS) / d; t_hi = (dmax << Q_BITS) / d.
  - Signed division, truncated toward zero.
  - Quotient saturates to [MIN, MAX].
- S2, per axis with d == 0:
  - If box.min.a <= origin.a <= box.max.a (inclusive), the slab is unbounded: near=MIN, far=MAX.
  - Otherwise the axis is flagged as a miss.
- S3, per axis: near = min(t_lo, t_hi), far = max(t_lo, t_hi).
- S3, across axes:
  - tn = max of the three nears; tf = min of the three fars.
  - Entry axis = axis supplying tn; on ties, priority x > y > z.
- S4 hit condition:
  - ray_hit = 1 iff no axis flagged miss, tn <= tf, and tf >= 0.
- S4 on hit:
  - tmin = max(tn, 0); origin inside the box gives 0.
  - normal = -sign(d_entry) * 1.0 on the entry axis (0xFFF000 when d > 0, 0x001000 when d < 0), 0 on the other axes.
  - If tn < 0 (inside the box), normal = 0.
- S4 on miss: ray_hit=0, tmin=MAX, normal=0.
- box is always passed through unchanged (hit or miss) so the downstream stage can read its colour.
- All comparisons are signed.
- Reset asserted mid-stream flushes every in-flight ray; no stale valid_out afterwards.
- Back-to-back start pulses produce back-to-back valid_out pulses in the same order.
- Gaps in start produce matching gaps in valid_out.

Test Plan:
1. Axial hit:
   - Box min(0,0,-1.0)=(0,0,0xFFF000), max(0x000C00,0x000C00,0x001000); ray origin (0,0,0xFFE000), dir (0,0,0x001000); start 1 cycle.
   - After 4 cycles valid_out=1, ray_hit=1, tmin=0x001000, normal=(0,0,0xFFF000), box.color=(FF,00,00).
2. Miss:
   - Same box; origin x=0xFFF800 (-0.5), dir (0,0,1.0).
   - ray_hit=0, tmin=0x7FFFFF, normal=0, box passed through.
3. X-entry:
   - Same box; origin (0xFFF000, 0x000400, 0), dir (0x001000, 0, 0).
   - ray_hit=1, tmin=0x001000, normal=(0xFFF000, 0, 0).
4. Inside and behind:
   - Origin (0x000400, 0x000400, 0), dir +z gives ray_hit=1, tmin=0, normal=0.
   - Origin z=0x002000, dir +z gives ray_hit=0.
5. Streaming:
   - 8 consecutive start cycles alternating scenarios 1 and 2.
   - 8 consecutive valid_out cycles with alternating hit/miss in order.
6. Reset mid-flight:
   - Assert reset 2 cycles after start.
   - valid_out stays 0 and outputs hold reset values; after release, a new ray completes in 4 cycles.
